// File: rtl/sky130_fd_io__hvclamp_seq_ctrl.sv
// ----------------------------------------------------------------------------
// sky130_fd_io__hvclamp_seq_ctrl
//
// Sequencer for the HV rail clamp override gate (ogc_hvc). The clamp stays
// armed while either VDDIO or VCCD power-good is missing or unstable. It is
// released only after both rails have been continuously good for a debounce
// window. A droop or a forced arm re-arms the clamp at once, and the clamp
// then stays armed for a minimum hold time. Droop-induced re-arms are counted
// in a saturating status counter.
// ----------------------------------------------------------------------------
module sky130_fd_io__hvclamp_seq_ctrl #(
    parameter int SYNC_STAGES  = 2,   // synchronizer depth, 2..4
    parameter int DEBOUNCE_CYC = 64,  // good cycles required before release
    parameter int HOLD_CYC     = 16,  // minimum armed time after a re-arm
    parameter int CNT_W        = 8    // droop event counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vddio_good_a,
    input  logic             vccd_good_a,
    input  logic             force_arm,
    input  logic             clr_events,
    output logic             ogc_arm,
    output logic             clamp_ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] event_cnt,
    output logic             sync_good
);

    // Timer must hold the larger of the two terminal counts; one spare bit
    // keeps it from ever wrapping.
    localparam int TMR_MAX = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASED = 2'd2,
        ST_HOLD     = 2'd3
    } state_e;

    // ------------------------------------------------------------------------
    // Power-good synchronizers
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] vddio_sync;
    logic [SYNC_STAGES-1:0] vccd_sync;
    logic                   good;

    // Shift both asynchronous power-good inputs through their flop chains.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour; blocking here would
        // collapse the chain into a single stage.
        if (rst) begin
            vddio_sync <= '0;
            vccd_sync  <= '0;
        end else begin
            vddio_sync <= {vddio_sync[SYNC_STAGES-2:0], vddio_good_a};
            vccd_sync  <= {vccd_sync[SYNC_STAGES-2:0],  vccd_good_a};
        end
    end

    // Both rails are considered good only when both last stages agree.
    assign good      = vddio_sync[SYNC_STAGES-1] & vccd_sync[SYNC_STAGES-1];
    assign sync_good = good;

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    state_e           state_q;
    state_e           state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             droop_event;

    // State and timer registers; reset re-arms with no hold and no event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARMED;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state, timer and droop-event decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        timer_d     = '0;
        droop_event = 1'b0;

        unique case (state_q)
            ST_ARMED: begin
                if (good && !force_arm) begin
                    state_d = ST_DEBOUNCE;
                end
            end

            ST_DEBOUNCE: begin
                if (!good || force_arm) begin
                    // Any glitch aborts; a full window restarts from ARMED.
                    state_d = ST_ARMED;
                end else if (timer_q == DEB_LAST) begin
                    state_d = ST_RELEASED;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_RELEASED: begin
                if (!good) begin
                    // A droop counts even when force_arm is also asserted.
                    state_d     = ST_HOLD;
                    droop_event = 1'b1;
                end else if (force_arm) begin
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // Inputs are ignored until the minimum armed time expires.
                if (timer_q == HOLD_LAST) begin
                    state_d = ST_ARMED;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_ARMED;
            end
        endcase
    end

    // Moore outputs: the clamp is armed in every state except RELEASED.
    always_comb begin
        state       = state_q;
        ogc_arm     = (state_q != ST_RELEASED);
        clamp_ready = (state_q == ST_RELEASED);
    end

    // ------------------------------------------------------------------------
    // Droop event counter
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] event_cnt_q;

    // Saturating count of droop re-arms; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_events) begin
            event_cnt_q <= '0;
        end else if (droop_event && (event_cnt_q != CNT_MAX)) begin
            event_cnt_q <= event_cnt_q + 1'b1;
        end
    end

    assign event_cnt = event_cnt_q;

endmodule

// File: tb/tb_sky130_fd_io__hvclamp_seq_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for sky130_fd_io__hvclamp_seq_ctrl.
// Directed table of {inputs, cycles, expected state/count}, hand sequences for
// counter saturation and reset, then randomized traffic against a reference
// model that tracks the sequencer as "consecutive good cycles" and "hold
// cycles remaining" rather than as a state machine.
// ----------------------------------------------------------------------------
module tb_sky130_fd_io__hvclamp_seq_ctrl;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int HOLD = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          vddio_good_a;
    logic          vccd_good_a;
    logic          force_arm;
    logic          clr_events;
    logic          ogc_arm;
    logic          clamp_ready;
    logic [1:0]    state;
    logic [CW-1:0] event_cnt;
    logic          sync_good;

    sky130_fd_io__hvclamp_seq_ctrl #(
        .SYNC_STAGES (SYNC),
        .DEBOUNCE_CYC(DEB),
        .HOLD_CYC    (HOLD),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vddio_good_a(vddio_good_a),
        .vccd_good_a (vccd_good_a),
        .force_arm   (force_arm),
        .clr_events  (clr_events),
        .ogc_arm     (ogc_arm),
        .clamp_ready (clamp_ready),
        .state       (state),
        .event_cnt   (event_cnt),
        .sync_good   (sync_good)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    //   run  : consecutive edges with (good && !force) while not released/hold;
    //          run >= 1 means debouncing, run == 1+DEB means released.
    //   hold : edges of forced-armed time still to serve after a re-arm.
    // ------------------------------------------------------------------------
    int m_run  = 0;
    int m_hold = 0;
    bit m_rel  = 0;
    int m_cnt  = 0;
    bit vq[$];
    bit cq[$];

    function automatic int m_state();
        if (m_hold > 0) return 3;
        if (m_rel)      return 2;
        if (m_run > 0)  return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_run  = 0;
        m_hold = 0;
        m_rel  = 0;
        m_cnt  = 0;
        vq.delete();
        cq.delete();
        for (int i = 0; i < SYNC; i++) begin
            vq.push_back(1'b0);
            cq.push_back(1'b0);
        end
    endtask

    task automatic model_step(input bit r, input bit vio, input bit vcc, input bit frc, input bit clr);
        bit g;
        bit inc;
        if (r) begin
            model_reset();
        end else begin
            g   = vq[0] && cq[0];
            inc = 1'b0;
            if (m_hold > 0) begin
                m_hold--;
            end else if (m_rel) begin
                if (!g) begin
                    m_rel  = 0;
                    m_hold = HOLD;
                    inc    = 1'b1;
                end else if (frc) begin
                    m_rel  = 0;
                    m_hold = HOLD;
                end
            end else begin
                m_run = (g && !frc) ? m_run + 1 : 0;
                if (m_run == 1 + DEB) begin
                    m_rel = 1;
                    m_run = 0;
                end
            end
            if (clr)      m_cnt = 0;
            else if (inc) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            void'(vq.pop_front());
            void'(cq.pop_front());
            vq.push_back(vio);
            cq.push_back(vcc);
        end
    endtask

    // Apply one cycle of inputs, then compare every output against the model.
    task automatic tick(input bit r, input bit vio, input bit vcc, input bit frc, input bit clr);
        int es;
        rst          = r;
        vddio_good_a = vio;
        vccd_good_a  = vcc;
        force_arm    = frc;
        clr_events   = clr;
        @(posedge clk);
        #1;
        model_step(r, vio, vcc, frc, clr);
        es = m_state();
        check("m_state",       32'(state),       32'(es));
        check("m_ogc_arm",     32'(ogc_arm),     32'(es != 2));
        check("m_clamp_ready", 32'(clamp_ready), 32'(es == 2));
        check("m_event_cnt",   32'(event_cnt),   32'(m_cnt));
        check("m_sync_good",   32'(sync_good),   32'(vq[0] && cq[0]));
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        bit r;
        bit vio;
        bit vcc;
        bit frc;
        bit clr;
        int n;     // cycles to hold these inputs
        int st;    // expected state after the last cycle
        int cnt;   // expected event_cnt after the last cycle
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit vio, bit vcc, bit frc, bit clr, int n, int st, int cnt);
        vec_t v;
        v.r = r; v.vio = vio; v.vcc = vcc; v.frc = frc; v.clr = clr;
        v.n = n; v.st = st; v.cnt = cnt;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        for (int i = 0; i < v.n; i++) tick(v.r, v.vio, v.vcc, v.frc, v.clr);
        check({tag, "_state"}, 32'(state), 32'(v.st));
        check({tag, "_cnt"},   32'(event_cnt), 32'(v.cnt));
        check({tag, "_ogc"},   32'(ogc_arm), 32'(v.st != 2));
    endtask

    // One droop on VDDIO from RELEASED; clr asserted on the edge that enters
    // HOLD when clr_on_hold is set. Leaves the design in HOLD.
    task automatic droop_to_hold(input bit clr_on_hold);
        tick(0, 0, 1, 0, 0);            // low sampled into stage 0
        tick(0, 1, 1, 0, 0);            // good now low at sync output
        tick(0, 1, 1, 0, clr_on_hold);  // RELEASED -> HOLD, event counted
    endtask

    task automatic recover_to_released();
        for (int i = 0; i < HOLD; i++) tick(0, 1, 1, 0, 0);  // HOLD -> ARMED
        for (int i = 0; i < 1 + DEB; i++) tick(0, 1, 1, 0, 0);
    endtask

    initial begin
        rst = 1'b1; vddio_good_a = 1'b0; vccd_good_a = 1'b0;
        force_arm = 1'b0; clr_events = 1'b0;
        model_reset();

        // Reset, power-up
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 2, 0, 0));   // edge 2: good just arrived
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0));   // edge 3: DEBOUNCE
        tbl.push_back(mk(0, 1, 1, 0, 0, 7, 1, 0));   // edge 10
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 2, 0));   // edge 11: RELEASED
        // Droop: VDDIO low one cycle
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 2, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 2, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 3, 1));   // HOLD, event counted
        tbl.push_back(mk(0, 1, 1, 0, 0, 3, 3, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1));   // exactly HOLD cycles
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 7, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 2, 1));
        // Forced arm from RELEASED
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 3, 1));   // HOLD, no event
        tbl.push_back(mk(0, 1, 1, 1, 0, 3, 3, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 5, 0, 1));   // stays ARMED while forced
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 7, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 2, 1));   // 9 edges after release
        // Debounce abort: get back into DEBOUNCE, glitch VCCD
        tbl.push_back(mk(0, 1, 1, 1, 0, 5, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 2, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1));   // aborted, no event
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1));   // re-entry
        tbl.push_back(mk(0, 1, 1, 0, 0, 7, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 2, 1));   // full window again
        // Reset mid-RELEASED, full sequence repeats
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 7, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 2, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end
        check("reset_sync_good_after_rel", 32'(sync_good), 32'd1);

        // Counter saturation: five droops from a cleared counter
        for (int d = 1; d <= 5; d++) begin
            droop_to_hold(1'b0);
            check($sformatf("sat_droop%0d", d), 32'(event_cnt), 32'((d < CMAX) ? d : CMAX));
            recover_to_released();
            check($sformatf("sat_rel%0d", d), 32'(clamp_ready), 32'd1);
        end
        // Sixth droop with clear on the same edge: clear wins
        droop_to_hold(1'b1);
        check("clr_wins_cnt",   32'(event_cnt), 32'd0);
        check("clr_wins_state", 32'(state), 32'd3);

        // Reset mid-HOLD
        tick(1, 1, 1, 0, 0);
        check("rst_hold_state", 32'(state), 32'd0);
        check("rst_hold_ogc",   32'(ogc_arm), 32'd1);
        check("rst_hold_ready", 32'(clamp_ready), 32'd0);
        check("rst_hold_cnt",   32'(event_cnt), 32'd0);
        check("rst_hold_sync",  32'(sync_good), 32'd0);
        for (int i = 0; i < SYNC + DEB; i++) tick(0, 1, 1, 0, 0);
        check("rst_hold_pre_rel", 32'(state), 32'd1);
        tick(0, 1, 1, 0, 0);
        check("rst_hold_rel", 32'(state), 32'd2);

        // Randomized traffic: rails mostly good, occasional force/clear/reset
        for (int i = 0; i < 4000; i++) begin
            bit r, vio, vcc, frc, clr;
            r   = ($urandom_range(0, 599) == 0);
            vio = ($urandom_range(0, 39) != 0);
            vcc = ($urandom_range(0, 39) != 0);
            frc = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 99) == 0);
            tick(r, vio, vcc, frc, clr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
